slew_monitor: RTL and testbench

//   Receive-side checker for the output stream of the 6-bit rate limiter.

---
 rtl/slew_monitor.sv | 167 ++++++++++++++++
 tb/tb_slew_monitor.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slew_monitor.sv
// ---------------------------------------------------------------------------
// slew_monitor
//   Receive-side checker for the output stream of the 6-bit rate limiter.
//   Each valid cycle it compares the limited sample against the previous one
//   and against the limiter's target. It flags steps that exceed max_step
//   and samples that cross the target. It also tracks the ramp direction,
//   the peak step and whether the stream has settled on the target.
//
// Ports
//   clk        in   1       system clock
//   rst        in   1       synchronous reset, active-high
//   clr        in   1       synchronous clear of statistics and history
//   smp_valid  in   1       smp/target/max_step valid this cycle
//   smp        in   WIDTH   limiter output sample
//   target     in   WIDTH   limiter input for the same cycle
//   max_step   in   STEP_W  allowed step magnitude
//   violation  out  1       1-cycle pulse: |step| > max_step
//   overshoot  out  1       1-cycle pulse: sample crossed the target
//   viol_cnt   out  CNT_W   saturating count of violation|overshoot events
//   peak_step  out  WIDTH   largest |step| seen since rst/clr
//   dir        out  2       00 IDLE, 01 UP, 10 DOWN, 11 HOLD
//   settled    out  1       level: on target for SETTLE_CYC samples
// ---------------------------------------------------------------------------
module slew_monitor #(
    parameter int WIDTH      = 6,
    parameter int STEP_W     = 3,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              smp_valid,
    input  logic [WIDTH-1:0]  smp,
    input  logic [WIDTH-1:0]  target,
    input  logic [STEP_W-1:0] max_step,
    output logic              violation,
    output logic              overshoot,
    output logic [CNT_W-1:0]  viol_cnt,
    output logic [WIDTH-1:0]  peak_step,
    output logic [1:0]        dir,
    output logic              settled
);

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_HOLD = 2'b11
    } dir_e;

    // SETTLE_CYC is at most 15, so four bits always hold the counter.
    localparam int              SC_W       = 4;
    localparam logic [SC_W-1:0] SETTLE_MAX = SC_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [WIDTH-1:0] prev_q,       prev_d;
    logic             have_prev_q,  have_prev_d;
    dir_e             dir_q,        dir_d;
    logic [SC_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] viol_cnt_q,   viol_cnt_d;
    logic [WIDTH-1:0] peak_q,       peak_d;
    logic             violation_q,  violation_d;
    logic             overshoot_q,  overshoot_d;
    logic             settled_q,    settled_d;

    // Step magnitude. Subtracting the smaller operand from the larger one
    // can never wrap, so 0 -> 63 yields 63 without an extra carry bit.
    logic [WIDTH-1:0] step;
    logic             step_viol;
    logic             crossed;

    always_comb begin
        step      = (smp >= prev_q) ? (smp - prev_q) : (prev_q - smp);
        step_viol = (step > WIDTH'(max_step));
        crossed   = ((prev_q < target) && (smp > target)) ||
                    ((prev_q > target) && (smp < target));
    end

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch so
        // no path leaves it unassigned; that is what keeps this block free
        // of inferred latches.
        prev_d       = prev_q;
        have_prev_d  = have_prev_q;
        dir_d        = dir_q;
        settle_cnt_d = settle_cnt_q;
        viol_cnt_d   = viol_cnt_q;
        peak_d       = peak_q;
        violation_d  = 1'b0;
        overshoot_d  = 1'b0;

        if (clr) begin
            // Same effect as reset; any sample in this cycle is dropped.
            prev_d       = '0;
            have_prev_d  = 1'b0;
            dir_d        = DIR_IDLE;
            settle_cnt_d = '0;
            viol_cnt_d   = '0;
            peak_d       = '0;
        end else if (smp_valid) begin
            prev_d      = smp;
            have_prev_d = 1'b1;

            // The first sample after rst/clr only primes the history.
            if (have_prev_q) begin
                violation_d = step_viol;
                overshoot_d = crossed;
                if ((step_viol || crossed) && (viol_cnt_q != CNT_MAX))
                    viol_cnt_d = viol_cnt_q + 1'b1;
                if (step > peak_q)
                    peak_d = step;
                if (smp > prev_q)
                    dir_d = DIR_UP;
                else if (smp < prev_q)
                    dir_d = DIR_DOWN;
                else
                    dir_d = DIR_HOLD;
            end

            // Settling runs on every valid sample, priming included.
            if (smp == target) begin
                if (settle_cnt_q != SETTLE_MAX)
                    settle_cnt_d = settle_cnt_q + 1'b1;
            end else begin
                settle_cnt_d = '0;
            end
        end

        settled_d = (settle_cnt_d == SETTLE_MAX);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: no memories here, so every register is reset explicitly.
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            dir_q        <= DIR_IDLE;
            settle_cnt_q <= '0;
            viol_cnt_q   <= '0;
            peak_q       <= '0;
            violation_q  <= 1'b0;
            overshoot_q  <= 1'b0;
            settled_q    <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            dir_q        <= dir_d;
            settle_cnt_q <= settle_cnt_d;
            viol_cnt_q   <= viol_cnt_d;
            peak_q       <= peak_d;
            violation_q  <= violation_d;
            overshoot_q  <= overshoot_d;
            settled_q    <= settled_d;
        end
    end

    assign violation = violation_q;
    assign overshoot = overshoot_q;
    assign viol_cnt  = viol_cnt_q;
    assign peak_step = peak_q;
    assign dir       = dir_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_slew_monitor.sv
// ---------------------------------------------------------------------------
// tb_slew_monitor
//   Self-checking bench for slew_monitor. Each driven cycle pushes the
//   expected outputs from a behavioural model onto a queue; a monitor pops
//   and compares them one cycle later. Scenario tasks add direct checks of
//   the values a reader can work out by hand.
// ---------------------------------------------------------------------------
module tb_slew_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       smp_valid = 1'b0;
    logic [5:0] smp = '0;
    logic [5:0] target = '0;
    logic [2:0] max_step = '0;
    logic       violation;
    logic       overshoot;
    logic [7:0] viol_cnt;
    logic [5:0] peak_step;
    logic [1:0] dir;
    logic       settled;

    slew_monitor #(.WIDTH(6), .STEP_W(3), .SETTLE_CYC(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .smp_valid (smp_valid),
        .smp       (smp),
        .target    (target),
        .max_step  (max_step),
        .violation (violation),
        .overshoot (overshoot),
        .viol_cnt  (viol_cnt),
        .peak_step (peak_step),
        .dir       (dir),
        .settled   (settled)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       viol;
        logic       over;
        logic [7:0] cnt;
        logic [5:0] peak;
        logic [1:0] dir;
        logic       settled;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model state.
    int m_prev = 0, m_have = 0, m_dir = 0, m_settle = 0, m_cnt = 0, m_peak = 0;

    task automatic model(input bit r, input bit c, input bit v,
                         input int s, input int t, input int mx);
        exp_t e;
        int   st;
        bit   vi, ov;
        vi = 1'b0;
        ov = 1'b0;
        if (r || c) begin
            m_prev = 0; m_have = 0; m_dir = 0; m_settle = 0; m_cnt = 0; m_peak = 0;
        end else if (v) begin
            if (m_have != 0) begin
                st = (s >= m_prev) ? s - m_prev : m_prev - s;
                vi = (st > mx);
                ov = (m_prev < t && s > t) || (m_prev > t && s < t);
                if ((vi || ov) && m_cnt < 255) m_cnt++;
                if (st > m_peak) m_peak = st;
                m_dir = (s > m_prev) ? 1 : (s < m_prev) ? 2 : 3;
            end
            m_prev = s;
            m_have = 1;
            if (s == t) begin
                if (m_settle < 4) m_settle++;
            end else begin
                m_settle = 0;
            end
        end
        e.viol    = vi;
        e.over    = ov;
        e.cnt     = 8'(m_cnt);
        e.peak    = 6'(m_peak);
        e.dir     = 2'(m_dir);
        e.settled = (m_settle == 4);
        sb.push_back(e);
    endtask

    // One clock cycle of stimulus; outputs are then stable for direct checks.
    task automatic drive(input bit r, input bit c, input bit v,
                         input int s, input int t, input int mx);
        @(negedge clk);
        rst       = r;
        clr       = c;
        smp_valid = v;
        smp       = 6'(s);
        target    = 6'(t);
        max_step  = 3'(mx);
        model(r, c, v, s, t, mx);
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: one expectation per driven cycle.
    always @(posedge clk) begin
        exp_t e, got;
        #1;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            got = '{violation, overshoot, viol_cnt, peak_step, dir, settled};
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL scoreboard t=%0t got viol=%b over=%b cnt=%0d peak=%0d dir=%b settled=%b exp viol=%b over=%b cnt=%0d peak=%0d dir=%b settled=%b",
                         $time, got.viol, got.over, got.cnt, got.peak, got.dir, got.settled,
                         e.viol, e.over, e.cnt, e.peak, e.dir, e.settled);
            end
        end
    end

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0);
        n_vec++;
        if ({violation, overshoot, viol_cnt, peak_step, dir, settled} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_state got cnt=%0d peak=%0d dir=%b settled=%b required all 0",
                     viol_cnt, peak_step, dir, settled);
        end
    endtask

    task automatic test_ramp();
        int seq[5] = '{0, 3, 6, 9, 10};
        drive(1, 0, 0, 0, 0, 0);
        foreach (seq[i]) drive(0, 0, 1, seq[i], 10, 3);
        n_vec++;
        if (dir !== 2'b01 || peak_step !== 6'd3 || viol_cnt !== 8'd0 || settled !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_end got dir=%b peak=%0d cnt=%0d settled=%b required 01 3 0 0",
                     dir, peak_step, viol_cnt, settled);
        end
        // First on-target sample already counted; three more reach 4.
        drive(0, 0, 1, 10, 10, 3);
        drive(0, 0, 1, 10, 10, 3);
        n_vec++;
        if (settled !== 1'b0) begin
            n_err++;
            $display("FAIL settle_early got %b required 0", settled);
        end
        drive(0, 0, 1, 10, 10, 3);
        n_vec++;
        if (settled !== 1'b1 || dir !== 2'b11) begin
            n_err++;
            $display("FAIL settle_done got settled=%b dir=%b required 1 11", settled, dir);
        end
    endtask

    task automatic test_violation();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 20, 40, 5);
        drive(0, 0, 1, 30, 40, 5);
        n_vec++;
        if (violation !== 1'b1 || overshoot !== 1'b0 || viol_cnt !== 8'd1 || peak_step !== 6'd10) begin
            n_err++;
            $display("FAIL step_violation got viol=%b over=%b cnt=%0d peak=%0d required 1 0 1 10",
                     violation, overshoot, viol_cnt, peak_step);
        end
        // Idle cycle: pulse drops, statistics hold.
        drive(0, 0, 0, 55, 0, 0);
        n_vec++;
        if (violation !== 1'b0 || viol_cnt !== 8'd1 || dir !== 2'b01) begin
            n_err++;
            $display("FAIL idle_hold got viol=%b cnt=%0d dir=%b required 0 1 01",
                     violation, viol_cnt, dir);
        end
    endtask

    task automatic test_overshoot();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 8, 10, 7);
        drive(0, 0, 1, 12, 10, 7);
        n_vec++;
        if (violation !== 1'b0 || overshoot !== 1'b1 || viol_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL overshoot_only got viol=%b over=%b cnt=%0d required 0 1 1",
                     violation, overshoot, viol_cnt);
        end
        drive(0, 0, 1, 2, 5, 3);
        n_vec++;
        if (violation !== 1'b1 || overshoot !== 1'b1 || viol_cnt !== 8'd2 || dir !== 2'b10) begin
            n_err++;
            $display("FAIL both_pulses got viol=%b over=%b cnt=%0d dir=%b required 1 1 2 10",
                     violation, overshoot, viol_cnt, dir);
        end
    endtask

    task automatic test_zero_step();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 5, 40, 0);
        drive(0, 0, 1, 5, 40, 0);
        n_vec++;
        if (dir !== 2'b11 || violation !== 1'b0) begin
            n_err++;
            $display("FAIL zero_step_hold got dir=%b viol=%b required 11 0", dir, violation);
        end
        drive(0, 0, 1, 6, 40, 0);
        n_vec++;
        if (violation !== 1'b1 || dir !== 2'b01) begin
            n_err++;
            $display("FAIL zero_step_change got viol=%b dir=%b required 1 01", violation, dir);
        end
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 63, 0);
        for (int i = 1; i <= 300; i++) drive(0, 0, 1, (i % 2) * 7, 63, 0);
        n_vec++;
        if (viol_cnt !== 8'd255 || violation !== 1'b1) begin
            n_err++;
            $display("FAIL cnt_saturate got cnt=%0d viol=%b required 255 1", viol_cnt, violation);
        end
    endtask

    task automatic test_boundary();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 63, 7);
        drive(0, 0, 1, 63, 63, 7);
        n_vec++;
        if (peak_step !== 6'd63 || violation !== 1'b1 || overshoot !== 1'b0) begin
            n_err++;
            $display("FAIL no_wrap got peak=%0d viol=%b over=%b required 63 1 0",
                     peak_step, violation, overshoot);
        end
        // Clear with a valid sample in the same cycle: sample is dropped.
        drive(0, 1, 1, 20, 20, 7);
        n_vec++;
        if ({violation, overshoot, viol_cnt, peak_step, dir, settled} !== 19'd0) begin
            n_err++;
            $display("FAIL clr_state got cnt=%0d peak=%0d dir=%b settled=%b required all 0",
                     viol_cnt, peak_step, dir, settled);
        end
        // If 20 had been kept, this sample would be checked (step 10 > 7).
        drive(0, 0, 1, 30, 30, 7);
        n_vec++;
        if (violation !== 1'b0 || dir !== 2'b00 || peak_step !== 6'd0) begin
            n_err++;
            $display("FAIL clr_discard got viol=%b dir=%b peak=%0d required 0 00 0",
                     violation, dir, peak_step);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 30, 30, 7);
        n_vec++;
        if (settled !== 1'b1) begin
            n_err++;
            $display("FAIL settle_before_rst got %b required 1", settled);
        end
        drive(1, 0, 1, 30, 30, 7);
        n_vec++;
        if (settled !== 1'b0 || dir !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_settle got settled=%b dir=%b required 0 00", settled, dir);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_violation();
        test_overshoot();
        test_zero_step();
        test_saturation();
        test_boundary();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
